// File: rtl/fifo_circular_pkg.sv
// Shared constants and helpers for the circular handshake FIFO.
package fifo_circular_pkg;

    localparam int DROP_CNT_W = 16;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_circular_mem.sv
// FIFO storage: one synchronous write port, one combinational read port, async clear.
module fifo_circular_mem #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_circular_hs.sv
// Circular FWFT FIFO with valid/ready on both sides, flush, threshold flags
// and occupancy/drop statistics.
module fifo_circular_hs
    import fifo_circular_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    input  logic [WIDTH-1:0]        in_data_i,
    output logic                    in_ready_o,
    output logic                    out_valid_o,
    output logic [WIDTH-1:0]        out_data_o,
    input  logic                    out_ready_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o,
    output logic [$clog2(DEPTH):0]  max_count_o,
    output logic [DROP_CNT_W-1:0]   drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THRESH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fifo_circular_hs: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      max_q, max_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  push, pop, drop_hit;
    logic [WIDTH-1:0]      rdata;

    // Ready depends only on state, so there is no comb path from out_ready_i.
    assign in_ready_o  = rstn_i & (count_q != FULL_C);
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign drop_hit    = in_valid_i & ~in_ready_o & rstn_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        max_d   = max_q;
        drop_d  = drop_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            max_d   = '0;
            drop_d  = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop);
            tail_d  = tail_q + PTR_W'(push);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            max_d   = (count_d > max_q) ? count_d : max_q;
            if (drop_hit) begin
                drop_d = sat_inc(drop_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            max_q   <= '0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            max_q   <= max_d;
            drop_q  <= drop_d;
        end
    end

    fifo_circular_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .we_i    (push & ~flush_i),
        .waddr_i (tail_q),
        .wdata_i (in_data_i),
        .raddr_i (head_q),
        .rdata_o (rdata)
    );

    assign out_data_o     = out_valid_o ? rdata : '0;
    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign max_count_o    = max_q;
    assign drop_cnt_o     = drop_q;

endmodule
